// File: rtl/display_estados_mux_if.sv
// Bundles the state-code inputs, load/blink/enable controls and the
// seven-segment pin outputs of display_estados_mux.
//   estados   : 3-bit state code per digit, digit i in bits [3i+2:3i]
//   carregar  : load strobe (captured every rising edge it is high)
//   pisca     : per-digit blink mask, applied live
//   habilita  : 1 = scanning, 0 = freeze and blank
//   segmentos : registered segment pins, bit0 = a ... bit6 = g
//   anodos    : registered digit-select pins, at most one active
// Handshake: there is none. Inputs are plain level/strobe signals sampled on
// every rising clock edge; outputs are free-running registered pin values.
interface display_estados_mux_if #(
  parameter int DIGITOS = 4
);
  logic [3*DIGITOS-1:0] estados;
  logic                 carregar;
  logic [DIGITOS-1:0]   pisca;
  logic                 habilita;
  logic [6:0]           segmentos;
  logic [DIGITOS-1:0]   anodos;

  modport master (
    output estados, carregar, pisca, habilita,
    input  segmentos, anodos
  );

  modport slave (
    input  estados, carregar, pisca, habilita,
    output segmentos, anodos
  );
endinterface

// File: rtl/display_estados_mux.sv
// Multiplexed seven-segment driver: one 3-bit system state code per digit,
// rendered as a fixed glyph, scanned over a shared segment bus.
//   clock   : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : display_estados_mux_if slave (estados, carregar, pisca,
//             habilita in; segmentos, anodos out)
// Parameters: DIGITOS digits, DIV clocks per digit slot, PISCA frames per
// blink half-period, ATIVO_BAIXO selects active-low pins.
module display_estados_mux #(
  parameter int DIGITOS     = 4,
  parameter int DIV         = 50000,
  parameter int PISCA       = 64,
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  display_estados_mux_if.slave  bus
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
  localparam int QW = (PISCA > 1) ? $clog2(PISCA) : 1;

  localparam logic [CW-1:0] DIV_MAX    = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(DIGITOS - 1);
  localparam logic [QW-1:0] QUADRO_MAX = QW'(PISCA - 1);

  // XOR masks that convert logical "lit/selected = 1" into pin polarity;
  // they are also the all-off pin values.
  localparam logic [6:0]         SEG_OFF = {7{ATIVO_BAIXO}};
  localparam logic [DIGITOS-1:0] AN_OFF  = {DIGITOS{ATIVO_BAIXO}};

  logic [3*DIGITOS-1:0] r_pend;
  logic [3*DIGITOS-1:0] r_ativo;
  logic [CW-1:0]        r_cnt_div;
  logic [IW-1:0]        r_idx;
  logic [QW-1:0]        r_cnt_quadro;
  logic                 r_fase;
  logic [6:0]           r_segmentos;
  logic [DIGITOS-1:0]   r_anodos;

  logic                 w_div_fim;
  logic                 w_quadro;
  logic [2:0]           w_codigo;
  logic                 w_pisca_sel;
  logic [DIGITOS-1:0]   w_an_sel;
  logic [6:0]           w_seg_log;
  logic [DIGITOS-1:0]   w_an_log;

  // Glyph table, bit 6..0 = g..a, 1 = lit.
  function automatic logic [6:0] glyph(input logic [2:0] codigo);
    logic [6:0] g;
    case (codigo)
      3'd0:    g = 7'b1000000; // '-'
      3'd1:    g = 7'b1110111; // 'A'
      3'd2:    g = 7'b1111001; // 'E'
      3'd3:    g = 7'b1110001; // 'F'
      3'd4:    g = 7'b1110011; // 'P'
      3'd5:    g = 7'b0111001; // 'C'
      3'd6:    g = 7'b0111000; // 'L'
      default: g = 7'b1110110; // 'H'
    endcase
    return g;
  endfunction

  assign w_div_fim = (r_cnt_div == DIV_MAX);
  // Frame boundary: last cycle of the last digit slot while scanning.
  assign w_quadro  = bus.habilita && w_div_fim && (r_idx == IDX_MAX);

  // Select the current digit's code, blink bit and anode by comparison
  // rather than a variable part-select, so any DIGITOS stays in range.
  always_comb begin
    w_codigo    = 3'd0;
    w_pisca_sel = 1'b0;
    w_an_sel    = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (r_idx == IW'(i)) begin
        w_codigo    = r_ativo[3*i +: 3];
        w_pisca_sel = bus.pisca[i];
        w_an_sel[i] = 1'b1;
      end
    end
  end

  // Slot position 0 is the dead-time cycle that hides ghosting between
  // digits; blinked-off digits keep their anode driven with blank segments.
  always_comb begin
    w_seg_log = '0;
    w_an_log  = '0;
    if (bus.habilita && (r_cnt_div != '0)) begin
      w_an_log = w_an_sel;
      if (!(w_pisca_sel && !r_fase)) begin
        w_seg_log = glyph(w_codigo);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pend       <= '0;
      r_ativo      <= '0;
      r_cnt_div    <= '0;
      r_idx        <= '0;
      r_cnt_quadro <= '0;
      r_fase       <= 1'b1;
      r_segmentos  <= SEG_OFF;
      r_anodos     <= AN_OFF;
    end else begin
      if (bus.carregar) begin
        r_pend <= bus.estados;
      end

      if (bus.habilita) begin
        r_cnt_div <= w_div_fim ? '0 : r_cnt_div + 1'b1;
        if (w_div_fim) begin
          r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end
      end

      // A load coinciding with the boundary bypasses pend so it is shown
      // in the very next frame.
      if (w_quadro) begin
        r_ativo <= bus.carregar ? bus.estados : r_pend;
        if (r_cnt_quadro == QUADRO_MAX) begin
          r_cnt_quadro <= '0;
          r_fase       <= ~r_fase;
        end else begin
          r_cnt_quadro <= r_cnt_quadro + 1'b1;
        end
      end

      r_segmentos <= w_seg_log ^ SEG_OFF;
      r_anodos    <= w_an_log ^ AN_OFF;
    end
  end

  assign bus.segmentos = r_segmentos;
  assign bus.anodos    = r_anodos;

endmodule
